// File: rtl/riscv_mem_arbiter.sv
// Two-to-one round-robin APB arbiter: captures the winning requester's transfer
// and replays it on the shared downstream memory port.
module riscv_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              imem_psel_i,
  input  logic              imem_penable_i,
  input  logic [ADDR_W-1:0] imem_paddr_i,
  input  logic              imem_pwrite_i,
  input  logic [DATA_W-1:0] imem_pwdata_i,
  output logic              imem_pready_o,
  output logic [DATA_W-1:0] imem_prdata_o,

  input  logic              dmem_psel_i,
  input  logic              dmem_penable_i,
  input  logic [ADDR_W-1:0] dmem_paddr_i,
  input  logic              dmem_pwrite_i,
  input  logic [DATA_W-1:0] dmem_pwdata_i,
  output logic              dmem_pready_o,
  output logic [DATA_W-1:0] dmem_prdata_o,

  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic              pready_i,
  input  logic [DATA_W-1:0] prdata_i,

  output logic              busy_o,
  output logic              grant_dmem_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0] state;
  logic       last_dmem;
  logic       req_any;
  logic       win_d;
  logic       done;
  logic       unused_penable;

  // Requester penable plays no part in arbitration.
  assign unused_penable = imem_penable_i ^ dmem_penable_i;

  always_comb begin
    req_any = imem_psel_i | dmem_psel_i;
    // On a tie the side not served last time wins.
    win_d   = dmem_psel_i & (~imem_psel_i | ~last_dmem);
    done    = (state == ACCESS) & pready_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_dmem <= 1'b0;
      paddr_o   <= '0;
      pwrite_o  <= 1'b0;
      pwdata_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            state     <= SETUP;
            last_dmem <= win_d;
            paddr_o   <= win_d ? dmem_paddr_i  : imem_paddr_i;
            pwrite_o  <= win_d ? dmem_pwrite_i : imem_pwrite_i;
            pwdata_o  <= win_d ? dmem_pwdata_i : imem_pwdata_i;
          end
        end
        SETUP:   state <= ACCESS;
        ACCESS:  if (pready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign psel_o        = (state == SETUP) | (state == ACCESS);
  assign penable_o     = (state == ACCESS);
  assign busy_o        = psel_o;
  assign grant_dmem_o  = last_dmem;

  assign imem_pready_o = done & ~last_dmem;
  assign dmem_pready_o = done & last_dmem;
  assign imem_prdata_o = imem_pready_o ? prdata_i : '0;
  assign dmem_prdata_o = dmem_pready_o ? prdata_i : '0;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: a per-cycle vector table plus
// hand-written sequences for round-robin, reset mid-transfer and psel drop.
module tb_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_psel, imem_penable, imem_pwrite, imem_pready;
  logic [31:0] imem_paddr, imem_pwdata, imem_prdata;
  logic        dmem_psel, dmem_penable, dmem_pwrite, dmem_pready;
  logic [31:0] dmem_paddr, dmem_pwdata, dmem_prdata;
  logic        psel, penable, pwrite, pready, busy, grant_dmem;
  logic [31:0] paddr, pwdata, prdata;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_psel_i    (imem_psel),
    .imem_penable_i (imem_penable),
    .imem_paddr_i   (imem_paddr),
    .imem_pwrite_i  (imem_pwrite),
    .imem_pwdata_i  (imem_pwdata),
    .imem_pready_o  (imem_pready),
    .imem_prdata_o  (imem_prdata),
    .dmem_psel_i    (dmem_psel),
    .dmem_penable_i (dmem_penable),
    .dmem_paddr_i   (dmem_paddr),
    .dmem_pwrite_i  (dmem_pwrite),
    .dmem_pwdata_i  (dmem_pwdata),
    .dmem_pready_o  (dmem_pready),
    .dmem_prdata_o  (dmem_prdata),
    .psel_o         (psel),
    .penable_o      (penable),
    .paddr_o        (paddr),
    .pwrite_o       (pwrite),
    .pwdata_o       (pwdata),
    .pready_i       (pready),
    .prdata_i       (prdata),
    .busy_o         (busy),
    .grant_dmem_o   (grant_dmem)
  );

  typedef struct {
    logic        rst;
    logic        ip;  logic [31:0] ia; logic iw; logic [31:0] id;
    logic        dp;  logic [31:0] da; logic dw; logic [31:0] dd;
    logic        rdy; logic [31:0] rd;
    logic        e_sel, e_en, e_wr, e_gnt;
    logic [31:0] e_addr, e_wd;
    logic        e_irdy; logic [31:0] e_ird;
    logic        e_drdy; logic [31:0] e_drd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [31:0] rst, ip, ia, iw, id, dp, da, dw, dd, rdy, rd,
                              sel, en, wr, gnt, addr, wd, irdy, ird, drdy, drd);
    vec_t v;
    v.rst = rst[0];
    v.ip = ip[0]; v.ia = ia; v.iw = iw[0]; v.id = id;
    v.dp = dp[0]; v.da = da; v.dw = dw[0]; v.dd = dd;
    v.rdy = rdy[0]; v.rd = rd;
    v.e_sel = sel[0]; v.e_en = en[0]; v.e_wr = wr[0]; v.e_gnt = gnt[0];
    v.e_addr = addr; v.e_wd = wd;
    v.e_irdy = irdy[0]; v.e_ird = ird; v.e_drdy = drdy[0]; v.e_drd = drd;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic clear_inputs();
    imem_psel = 0; imem_penable = 0; imem_paddr = 0; imem_pwrite = 0; imem_pwdata = 0;
    dmem_psel = 0; dmem_penable = 0; dmem_paddr = 0; dmem_pwrite = 0; dmem_pwdata = 0;
    pready = 0; prdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Waits for any requester completion; returns the number of edges crossed.
  task automatic wait_done(output int cycles, output logic ok);
    cycles = 0;
    ok = 0;
    while (cycles < 20) begin
      @(negedge clk);
      if (imem_pready | dmem_pready) begin
        ok = 1;
        break;
      end
      step();
      cycles++;
    end
  endtask

  initial begin
    int   cyc;
    logic ok;
    logic exp_g;

    clear_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset ctrl", {psel, penable, pwrite, busy, grant_dmem}, 0);
    chk("reset paddr", paddr, 0);
    chk("reset pwdata", pwdata, 0);
    chk("reset imem resp", {imem_pready, imem_prdata}, 0);
    chk("reset dmem resp", {dmem_pready, dmem_prdata}, 0);
    step();

    //   rst ip ia      iw id  dp da      dw dd            rdy rd              sel en wr g addr    wd            irdy ird          drdy drd
    // single imem read
    add(0, 1,'h100, 0,0,  0,0,     0,0,           1,'hDEADBEEF,   0,0,0,0,'h0,   0,            0,0,           0,0);
    add(0, 1,'h100, 0,0,  0,0,     0,0,           1,'hDEADBEEF,   1,0,0,0,'h100, 0,            0,0,           0,0);
    add(0, 1,'h100, 0,0,  0,0,     0,0,           1,'hDEADBEEF,   1,1,0,0,'h100, 0,            1,'hDEADBEEF,  0,0);
    add(0, 0,'h100, 0,0,  0,0,     0,0,           1,'hDEADBEEF,   0,0,0,0,'h100, 0,            0,0,           0,0);
    // reset, then simultaneous requests: dmem first
    add(1, 0,0,     0,0,  0,0,     0,0,           1,'hA5A50001,   0,0,0,0,'h100, 0,            0,0,           0,0);
    add(0, 1,'h10,  0,0,  1,'h20,  1,'h12345678,  1,'hA5A50001,   0,0,0,0,'h0,   0,            0,0,           0,0);
    add(0, 1,'h10,  0,0,  1,'h20,  1,'h12345678,  1,'hA5A50001,   1,0,1,1,'h20,  'h12345678,   0,0,           0,0);
    add(0, 1,'h10,  0,0,  1,'h20,  1,'h12345678,  1,'hA5A50001,   1,1,1,1,'h20,  'h12345678,   0,0,           1,'hA5A50001);
    add(0, 1,'h10,  0,0,  0,'h20,  1,'h12345678,  1,'hA5A50001,   0,0,1,1,'h20,  'h12345678,   0,0,           0,0);
    add(0, 1,'h10,  0,0,  0,0,     0,0,           1,'hA5A50001,   1,0,0,0,'h10,  0,            0,0,           0,0);
    add(0, 1,'h10,  0,0,  0,0,     0,0,           1,'hA5A50001,   1,1,0,0,'h10,  0,            1,'hA5A50001,  0,0);
    add(0, 0,0,     0,0,  0,0,     0,0,           1,'hA5A50001,   0,0,0,0,'h10,  0,            0,0,           0,0);
    // dmem write with four wait states while its inputs toggle
    add(0, 0,0,     0,0,  1,'h300, 1,'hCAFE0001,  0,'h5A5A0002,   0,0,0,0,'h10,  0,            0,0,           0,0);
    add(0, 0,0,     0,0,  1,'h304, 0,'h11111111,  0,'h5A5A0002,   1,0,1,1,'h300, 'hCAFE0001,   0,0,           0,0);
    add(0, 0,0,     0,0,  1,'h308, 1,'h22222222,  0,'h5A5A0002,   1,1,1,1,'h300, 'hCAFE0001,   0,0,           0,0);
    add(0, 0,0,     0,0,  1,'h30C, 0,'h33333333,  0,'h5A5A0002,   1,1,1,1,'h300, 'hCAFE0001,   0,0,           0,0);
    add(0, 0,0,     0,0,  1,'h310, 1,'h44444444,  0,'h5A5A0002,   1,1,1,1,'h300, 'hCAFE0001,   0,0,           0,0);
    add(0, 0,0,     0,0,  1,'h314, 0,'h55555555,  0,'h5A5A0002,   1,1,1,1,'h300, 'hCAFE0001,   0,0,           0,0);
    add(0, 0,0,     0,0,  1,'h300, 1,'hCAFE0001,  1,'h5A5A0002,   1,1,1,1,'h300, 'hCAFE0001,   0,0,           1,'h5A5A0002);
    add(0, 0,0,     0,0,  0,0,     0,0,           0,'h5A5A0002,   0,0,1,1,'h300, 'hCAFE0001,   0,0,           0,0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      imem_psel = vecs[i].ip; imem_paddr = vecs[i].ia; imem_pwrite = vecs[i].iw; imem_pwdata = vecs[i].id;
      dmem_psel = vecs[i].dp; dmem_paddr = vecs[i].da; dmem_pwrite = vecs[i].dw; dmem_pwdata = vecs[i].dd;
      pready = vecs[i].rdy; prdata = vecs[i].rd;
      @(negedge clk);
      chk($sformatf("row%0d ctrl", i), {psel, penable, pwrite, busy, grant_dmem},
          {vecs[i].e_sel, vecs[i].e_en, vecs[i].e_wr, vecs[i].e_sel, vecs[i].e_gnt});
      chk($sformatf("row%0d paddr", i), paddr, vecs[i].e_addr);
      chk($sformatf("row%0d pwdata", i), pwdata, vecs[i].e_wd);
      chk($sformatf("row%0d imem resp", i), {imem_pready, imem_prdata}, {vecs[i].e_irdy, vecs[i].e_ird});
      chk($sformatf("row%0d dmem resp", i), {dmem_pready, dmem_prdata}, {vecs[i].e_drdy, vecs[i].e_drd});
      step();
    end
    reset = 0;

    // Round-robin under continuous contention: 1,0,1,0,1,0, one completion per 3 cycles
    do_reset();
    imem_psel = 1; imem_paddr = 'h100; imem_pwrite = 0;
    dmem_psel = 1; dmem_paddr = 'h200; dmem_pwrite = 1; dmem_pwdata = 'h77;
    pready = 1; prdata = 'h1111;
    for (int k = 0; k < 6; k++) begin
      exp_g = (k % 2 == 0);
      wait_done(cyc, ok);
      chk($sformatf("rr%0d done", k), ok, 1);
      chk($sformatf("rr%0d latency", k), cyc, 2);
      chk($sformatf("rr%0d grant", k), grant_dmem, exp_g);
      chk($sformatf("rr%0d readies", k), {imem_pready, dmem_pready}, {!exp_g, exp_g});
      chk($sformatf("rr%0d paddr", k), paddr, exp_g ? 'h200 : 'h100);
      step();
    end

    // Reset mid-ACCESS of a dmem write
    do_reset();
    dmem_psel = 1; dmem_paddr = 'h40; dmem_pwrite = 1; dmem_pwdata = 'h99;
    imem_psel = 1; imem_paddr = 'h44;
    pready = 0;
    step(); step();
    @(negedge clk);
    chk("midrst access", {psel, penable, grant_dmem}, 3'b111);
    reset = 1;
    step();
    reset = 0;
    @(negedge clk);
    chk("midrst ctrl", {psel, penable, busy, grant_dmem}, 0);
    chk("midrst readies", {imem_pready, dmem_pready}, 0);
    chk("midrst paddr", paddr, 0);
    step();
    @(negedge clk);
    chk("midrst tie", {psel, grant_dmem}, 2'b11);
    chk("midrst tie paddr", paddr, 'h40);

    // imem drops psel during SETUP; dmem pending
    do_reset();
    imem_psel = 1; imem_paddr = 'h500; imem_pwrite = 0;
    pready = 1; prdata = 'hFEED;
    step();
    imem_psel = 0;
    dmem_psel = 1; dmem_paddr = 'h600; dmem_pwrite = 1; dmem_pwdata = 'hABC;
    @(negedge clk);
    chk("drop setup", {psel, penable, grant_dmem, imem_pready, dmem_pready}, 5'b10000);
    step();
    @(negedge clk);
    chk("drop resp", {imem_pready, imem_prdata}, {1'b1, 32'hFEED});
    chk("drop dmem quiet", dmem_pready, 0);
    step();
    @(negedge clk);
    chk("drop idle", {psel, imem_pready, dmem_pready}, 0);
    step();
    @(negedge clk);
    chk("drop next grant", {psel, grant_dmem, pwrite}, 3'b111);
    chk("drop next paddr", paddr, 'h600);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
